// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared DATA_WIDTH adder is stepped
// LSW-first across NUM_WORDS words, chaining carry through a register.

module adder_v #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Ci};
endmodule

// state | meaning
// IDLE  | in_ready=1, waiting for a request
// RUN   | one word per cycle through the shared adder, idx_q selects the word
// DONE  | result held with out_valid=1 until out_ready
module adder_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] A_in,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] B_in,
  input  logic                            Ci_in,
  input  logic                            Sub_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH*NUM_WORDS-1:0] Sum_out,
  output logic                            Cout_out,
  output logic                            Ovf_out
);
  localparam int W     = DATA_WIDTH * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          b_q, b_d;
  logic [W-1:0]          sum_q, sum_d;
  logic                  cout_q, cout_d;
  logic                  ovf_q, ovf_d;

  logic [DATA_WIDTH-1:0] a_word, b_word, add_sum;
  logic                  add_cout;
  logic                  is_last;

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_word = a_q[i*DATA_WIDTH +: DATA_WIDTH];
        b_word = b_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  adder_v #(.WIDTH(DATA_WIDTH)) u_adder (
    .A    (a_word),
    .B    (b_word),
    .Ci   (carry_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  assign is_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = A_in;
          b_d     = Sub_in ? ~B_in : B_in;
          carry_d = Sub_in ? 1'b1 : Ci_in;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*DATA_WIDTH +: DATA_WIDTH] = add_sum;
        end
        carry_d = add_cout;
        // idx holds on the last word so it never wraps
        if (is_last) begin
          cout_d  = add_cout;
          ovf_d   = (a_word[DATA_WIDTH-1] == b_word[DATA_WIDTH-1]) &&
                    (add_sum[DATA_WIDTH-1] != a_word[DATA_WIDTH-1]);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Sum_out   = sum_q;
  assign Cout_out  = cout_q;
  assign Ovf_out   = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl (DATA_WIDTH=8, NUM_WORDS=4): expectations are
// queued at accept time and a negedge monitor compares each delivered result.
module tb_adder_seq_ctrl;
  localparam int DW = 8;
  localparam int NW = 4;
  localparam int W  = DW * NW;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A_in = '0;
  logic [W-1:0] B_in = '0;
  logic         Ci_in = 1'b0;
  logic         Sub_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] Sum_out;
  logic         Cout_out;
  logic         Ovf_out;

  adder_seq_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_in      (A_in),
    .B_in      (B_in),
    .Ci_in     (Ci_in),
    .Sub_in    (Sub_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum_out   (Sum_out),
    .Cout_out  (Cout_out),
    .Ovf_out   (Ovf_out)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o;
    return e;
  endfunction

  // Independent W+1-bit reference for the random vectors
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    logic [W-1:0] be;
    logic         c;
    logic [W:0]   r;
    exp_t         e;
    be = sub ? ~b : b;
    c  = sub ? 1'b1 : ci;
    r  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none", Sum_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum",  Sum_out, mon_e.sum);
        chk("cout", {{(W-1){1'b0}}, Cout_out}, {{(W-1){1'b0}}, mon_e.cout});
        chk("ovf",  {{(W-1){1'b0}}, Ovf_out},  {{(W-1){1'b0}}, mon_e.ovf});
      end
    end
  end

  // Drive a request and wait (bounded) for its accept edge; returns at accept edge + 1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sub, input exp_t e, input bit push, input bit keep);
    bit ok;
    A_in = a; B_in = b; Ci_in = ci; Sub_in = sub; in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        if (push) exp_q.push_back(e);
        #1;
        acc_cyc = cyc;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout actual=0 required=1");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  {{(W-1){1'b0}}, in_ready},  {{(W-1){1'b0}}, 1'b1});
    chk({tag, "_out_valid"}, {{(W-1){1'b0}}, out_valid}, '0);
    chk({tag, "_sum"},       Sum_out, '0);
    chk({tag, "_cout"},      {{(W-1){1'b0}}, Cout_out},  '0);
    chk({tag, "_ovf"},       {{(W-1){1'b0}}, Ovf_out},   '0);
  endtask

  initial begin
    int c0;
    int prev;
    logic [W-1:0] ra, rb;
    logic rci, rsub;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Carry ripples through every word; latency accept->out_valid is NUM_WORDS edges
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0), 1'b1, 1'b0);
    c0 = acc_cyc;
    wait_valid();
    chk("latency", W'(cyc - c0), W'(NW));
    drain();

    send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b0), 1'b1, 1'b0);
    drain();
    send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0), 1'b1, 1'b0);
    drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1), 1'b1, 1'b0);
    drain();
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1), 1'b1, 1'b0);
    drain();
    send(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0100, 1'b0, 1'b0), 1'b1, 1'b0);
    drain();
    // Ci is a don't-care for subtract: 10-3 with Ci=0 still sees carry-in 1
    send(32'h0000_000A, 32'h0000_0003, 1'b0, 1'b1, mk(32'h0000_0007, 1'b1, 1'b0), 1'b1, 1'b0);
    drain();

    // Backpressure: result held, second request ignored until out_ready
    out_ready = 1'b0;
    send(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0, mk(32'h1122_3344, 1'b0, 1'b0), 1'b1, 1'b0);
    wait_valid();
    A_in = 32'h0000_0010; B_in = 32'h0000_0020; Ci_in = 1'b0; Sub_in = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
      chk("bp_sum",       Sum_out, 32'h1122_3344);
      chk("bp_in_ready",  {{(W-1){1'b0}}, in_ready}, '0);
    end
    @(posedge clk);
    #1;
    c0 = cyc;
    out_ready = 1'b1;
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, mk(32'h0000_0030, 1'b0, 1'b0), 1'b1, 1'b0);
    chk("bp_accept_cycle", W'(acc_cyc - c0), W'(2));
    drain();

    // Reset during the second RUN cycle discards the op entirely
    send(32'h0000_00AA, 32'h0000_0011, 1'b0, 1'b0, mk('0, 1'b0, 1'b0), 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("partial_word0", {24'h0, Sum_out[7:0]}, 32'h0000_00BB);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0), 1'b1, 1'b0);
    drain();

    // Back-to-back with in_valid held: accept-to-accept is NUM_WORDS RUN cycles + DONE + IDLE
    send(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0, mk(32'h3333_3334, 1'b0, 1'b0), 1'b1, 1'b1);
    prev = acc_cyc;
    send(32'h0000_FFFF, 32'h0001_0000, 1'b0, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b0), 1'b1, 1'b1);
    chk("b2b_spacing", W'(acc_cyc - prev), W'(NW + 2));
    prev = acc_cyc;
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b1), 1'b1, 1'b1);
    chk("b2b_spacing", W'(acc_cyc - prev), W'(NW + 2));
    prev = acc_cyc;

    for (int k = 0; k < 120; k++) begin
      ra = $urandom();
      rb = $urandom();
      rci = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      send(ra, rb, rci, rsub, model(ra, rb, rci, rsub), 1'b1, (k != 119));
      chk("rand_spacing", W'(acc_cyc - prev), W'(NW + 2));
      prev = acc_cyc;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
